// File: rtl/detector_arbiter.sv
// Round-robin arbiter that time-shares one a-then-b sequence detector among N channels.
// Define DETECTOR_ARB_FIXED_PRIO_EN to switch arbitration to fixed lowest-index priority.
module detector_arbiter #(
  parameter int N      = 4,
  parameter int WINDOW = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  input  logic         det_y,
  output logic [N-1:0] gnt,
  output logic         det_clr,
  output logic         det_a,
  output logic         det_b,
  output logic [N-1:0] hit,
  output logic [N-1:0] done,
  output logic         busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t        state, next;
  logic [IW-1:0] cur;
  logic [IW-1:0] sel;
  logic [TW-1:0] timer;
  logic          hit_flag;
  logic          run_exit;

`ifdef DETECTOR_ARB_FIXED_PRIO_EN
  // Walk downward so the lowest requesting index is the final assignment.
  always_comb begin
    sel = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (req[IW'(i - 1)]) sel = IW'(i - 1);
    end
  end
`else
  logic [IW-1:0] last;

  // Walk offsets downward so the nearest requester after last is the final assignment.
  always_comb begin
    int unsigned   k;
    logic [IW-1:0] kk;
    sel = '0;
    for (int unsigned i = N; i >= 1; i--) begin
      k  = (32'(last) + i) % N;
      kk = IW'(k);
      if (req[kk]) sel = kk;
    end
  end
`endif

  // Detector hit outranks abort, which outranks timeout; all three end the grant.
  assign run_exit = det_y || !req[cur] || (timer == TW'(1));

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (|req) next = CLEAR;
      CLEAR:   next = RUN;
      RUN:     if (run_exit) next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    det_clr = (state == CLEAR);
    det_a   = (state == RUN) ? a_in[cur] : 1'b0;
    det_b   = (state == RUN) ? b_in[cur] : 1'b0;
    busy    = (state != IDLE);
    done    = (state == DONE) ? (N'(1) << cur) : '0;
    hit     = (state == DONE && hit_flag) ? (N'(1) << cur) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      cur      <= '0;
      timer    <= '0;
      hit_flag <= 1'b0;
`ifndef DETECTOR_ARB_FIXED_PRIO_EN
      last     <= IW'(N - 1);
`endif
    end else begin
      state <= next;
      case (state)
        IDLE: begin
          if (|req) begin
            cur <= sel;
            gnt <= N'(1) << sel;
`ifndef DETECTOR_ARB_FIXED_PRIO_EN
            last <= sel;
`endif
          end
        end
        CLEAR: timer <= TW'(WINDOW);
        RUN: begin
          if (timer != '0) timer <= timer - TW'(1);
          if (run_exit) begin
            gnt      <= '0;
            hit_flag <= det_y;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
